// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: side-port program/data load, start/done/err handshake.
// Build option: define MIPS_CORE_SW_EN to implement sw (opcode 0x2B); otherwise it traps to ERR.
module mips_multicycle_core #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NREG       = 32,
    parameter int unsigned IMEM_DEPTH = 16,
    parameter int unsigned DMEM_DEPTH = 16,
    parameter int unsigned START_PC   = 0,
    parameter int unsigned OUT_REG    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_we,
    input  logic              ld_imem,
    input  logic [7:0]        ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [7:0]        end_pc,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] led
);
    localparam int unsigned RAW = $clog2(NREG);
    localparam int unsigned IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StDone, StErr
    } state_e;

    state_e            state_q;
    logic [7:0]        pc_q, npc_q;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, imm_q, res_q, led_q;
    logic [RAW-1:0]    wr_idx_q;
    logic              wr_en_q, is_mem_q;
    logic              busy_q, done_q, err_q;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [31:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    logic [7:0]        pc_inc, br_tgt;
    logic [DATA_W-1:0] ex_res, out_val;
    logic [7:0]        ex_npc;
    logic [RAW-1:0]    ex_idx;
    logic              ex_wr, ex_mem, ex_bad;
    logic              ld_ok, mem_ok;

    assign pc_inc = pc_q + 8'd1;
    assign br_tgt = pc_q + 8'd1 + ir_q[7:0];
    assign mem_ok = 32'(res_q) < DMEM_DEPTH;

`ifdef MIPS_CORE_SW_EN
    logic ex_sw, is_sw_q, sw_fire;
    assign sw_fire = !rst && (state_q == StMem) && is_sw_q && mem_ok;
`endif

    // Execute-stage decode: ALU result, destination, next PC and trap detection.
    always_comb begin
        ex_res = '0;
        ex_npc = pc_inc;
        ex_idx = ir_q[11 +: RAW];
        ex_wr  = 1'b0;
        ex_mem = 1'b0;
        ex_bad = 1'b0;
`ifdef MIPS_CORE_SW_EN
        ex_sw  = 1'b0;
`endif
        case (ir_q[31:26])
            6'h00: begin
                ex_wr = 1'b1;
                case (ir_q[5:0])
                    6'h21: ex_res = a_q + b_q;
                    6'h23: ex_res = a_q - b_q;
                    6'h24: ex_res = a_q & b_q;
                    6'h25: ex_res = a_q | b_q;
                    6'h2A: ex_res = DATA_W'($signed(a_q) < $signed(b_q));
                    6'h08: begin
                        ex_wr  = 1'b0;
                        ex_npc = 8'(a_q);
                    end
                    default: begin
                        ex_wr  = 1'b0;
                        ex_bad = 1'b1;
                    end
                endcase
            end
            6'h09: begin
                ex_res = a_q + imm_q;
                ex_idx = ir_q[16 +: RAW];
                ex_wr  = 1'b1;
            end
            6'h04: if (a_q == b_q) ex_npc = br_tgt;
            6'h05: if (a_q != b_q) ex_npc = br_tgt;
            6'h23: begin
                ex_res = a_q + imm_q;
                ex_idx = ir_q[16 +: RAW];
                ex_wr  = 1'b1;
                ex_mem = 1'b1;
            end
`ifdef MIPS_CORE_SW_EN
            6'h2B: begin
                ex_res = a_q + imm_q;
                ex_mem = 1'b1;
                ex_sw  = 1'b1;
            end
`endif
            6'h02: ex_npc = ir_q[7:0];
            6'h03: begin
                ex_npc = ir_q[7:0];
                ex_res = DATA_W'(pc_inc);
                ex_idx = RAW'(NREG - 1);
                ex_wr  = 1'b1;
            end
            default: ex_bad = 1'b1;
        endcase
    end

    // A final instruction that writes OUT_REG must be visible in led on the same edge.
    always_comb begin
        out_val = rf_q[OUT_REG];
        if (wr_en_q && (wr_idx_q != '0) && (wr_idx_q == RAW'(OUT_REG))) out_val = res_q;
    end

    assign ld_ok = ld_we && !rst &&
                   ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));

    always_ff @(posedge clk) begin
        if (ld_ok && ld_imem && (32'(ld_addr) < IMEM_DEPTH)) imem[IAW'(ld_addr)] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (ld_ok && !ld_imem && (32'(ld_addr) < DMEM_DEPTH)) begin
            dmem[DAW'(ld_addr)] <= ld_data[DATA_W-1:0];
        end
`ifdef MIPS_CORE_SW_EN
        else if (sw_fire) begin
            dmem[DAW'(res_q)] <= b_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= 8'(START_PC);
            npc_q    <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            res_q    <= '0;
            wr_idx_q <= '0;
            wr_en_q  <= 1'b0;
            is_mem_q <= 1'b0;
`ifdef MIPS_CORE_SW_EN
            is_sw_q  <= 1'b0;
`endif
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            led_q    <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        pc_q    <= 8'(START_PC);
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StFetch;
                        for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
                    end
                end
                StFetch: begin
                    if (32'(pc_q) >= IMEM_DEPTH) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StErr;
                    end else begin
                        ir_q    <= imem[IAW'(pc_q)];
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    a_q     <= rf_q[ir_q[21 +: RAW]];
                    b_q     <= rf_q[ir_q[16 +: RAW]];
                    imm_q   <= DATA_W'({{16{ir_q[15]}}, ir_q[15:0]});
                    state_q <= StExec;
                end
                StExec: begin
                    if (ex_bad) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StErr;
                    end else begin
                        res_q    <= ex_res;
                        npc_q    <= ex_npc;
                        wr_en_q  <= ex_wr;
                        wr_idx_q <= ex_idx;
                        is_mem_q <= ex_mem;
`ifdef MIPS_CORE_SW_EN
                        is_sw_q  <= ex_sw;
`endif
                        state_q  <= ex_mem ? StMem : StWb;
                    end
                end
                StMem: begin
                    // Out-of-range address traps before any load or store takes effect.
                    if (!mem_ok) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StErr;
                    end else begin
`ifdef MIPS_CORE_SW_EN
                        if (!is_sw_q) res_q <= dmem[DAW'(res_q)];
`else
                        res_q <= dmem[DAW'(res_q)];
`endif
                        state_q <= StWb;
                    end
                end
                StWb: begin
                    if (wr_en_q && (wr_idx_q != '0)) rf_q[wr_idx_q] <= res_q;
                    pc_q     <= npc_q;
                    is_mem_q <= 1'b0;
                    if (npc_q == end_pc) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        led_q   <= out_val;
                        state_q <= StDone;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign led  = led_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: directed programs plus randomized programs
// compared against an instruction-level reference interpreter.
module tb_mips_multicycle_core;
    localparam int DW = 8;
`ifdef MIPS_CORE_SW_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic          clk, rst, ld_we, ld_imem, start, busy, done, err;
    logic [7:0]    ld_addr, end_pc;
    logic [31:0]   ld_data;
    logic [DW-1:0] led;

    int errors = 0;
    int checks = 0;
    int ref_imem[16];
    int ref_dmem[16];
    int mreg[32];
    int m_led, m_pc, m_cyc;
    bit m_err, m_hang;
    int trace[$];
    int tcyc[$];
    int first_cyc;

    mips_multicycle_core #(
        .DATA_W(DW), .NREG(32), .IMEM_DEPTH(16), .DMEM_DEPTH(16), .START_PC(0), .OUT_REG(2)
    ) dut (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_imem(ld_imem), .ld_addr(ld_addr),
        .ld_data(ld_data), .end_pc(end_pc), .start(start), .busy(busy), .done(done),
        .err(err), .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int enc_r(int rs, int rt, int rd, int fn);
        return (rs << 21) | (rt << 16) | (rd << 11) | fn;
    endfunction
    function automatic int enc_i(int op, int rs, int rt, int imm);
        return (op << 26) | (rs << 21) | (rt << 16) | (imm & 'hFFFF);
    endfunction
    function automatic int enc_j(int op, int tgt);
        return (op << 26) | tgt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Instruction-set interpreter: runs ref_imem/ref_dmem to completion, trap or step limit.
    task automatic model_run(input int endpc);
        int pc, ins, op, rs, rt, rd, fn, simm, a, b, nxt, addr, wd, wv, sa, sb;
        bit wr, bad, mem, st;
        for (int i = 0; i < 32; i++) mreg[i] = 0;
        pc = 0; m_cyc = 0; m_err = 0; m_hang = 1;
        for (int step = 0; step < 100; step++) begin
            if (pc >= 16) begin m_err = 1; m_hang = 0; m_cyc += 1; break; end
            ins = ref_imem[pc];
            op = (ins >> 26) & 63; rs = (ins >> 21) & 31; rt = (ins >> 16) & 31;
            rd = (ins >> 11) & 31; fn = ins & 63;
            simm = ins & 65535;
            if (simm >= 32768) simm -= 65536;
            a = mreg[rs]; b = mreg[rt];
            nxt = (pc + 1) % 256; wr = 0; wd = rd; wv = 0; bad = 0; mem = 0; st = 0;
            case (op)
                0: begin
                    wr = 1;
                    case (fn)
                        'h21: wv = a + b;
                        'h23: wv = a - b;
                        'h24: wv = a & b;
                        'h25: wv = a | b;
                        'h2A: begin
                            sa = (a >= 128) ? a - 256 : a;
                            sb = (b >= 128) ? b - 256 : b;
                            wv = (sa < sb) ? 1 : 0;
                        end
                        'h08: begin wr = 0; nxt = a; end
                        default: bad = 1;
                    endcase
                end
                'h09: begin wr = 1; wd = rt; wv = a + simm; end
                'h04: if (a == b) nxt = (pc + 1 + simm) & 255;
                'h05: if (a != b) nxt = (pc + 1 + simm) & 255;
                'h23: begin mem = 1; wr = 1; wd = rt; end
                'h2B: begin mem = 1; st = 1; bad = !SW_EN; end
                'h02: nxt = ins & 255;
                'h03: begin nxt = ins & 255; wr = 1; wd = 31; wv = pc + 1; end
                default: bad = 1;
            endcase
            if (bad) begin m_err = 1; m_hang = 0; m_cyc += 3; break; end
            if (mem) begin
                addr = (a + simm) & 255;
                if (addr >= 16) begin m_err = 1; m_hang = 0; m_cyc += 4; break; end
                if (st) ref_dmem[addr] = b & 255;
                else wv = ref_dmem[addr];
                m_cyc += 1;
            end
            m_cyc += 4;
            if (wr && wd != 0) mreg[wd] = wv & 255;
            pc = nxt;
            if (pc == endpc) begin m_led = mreg[2]; m_hang = 0; break; end
        end
        m_pc = pc;
    endtask

    task automatic ld(input bit im, input int addr, input int data);
        @(negedge clk);
        ld_we = 1'b1; ld_imem = im; ld_addr = 8'(addr); ld_data = 32'(data);
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++) ld(1'b1, i, ref_imem[i]);
        for (int i = 0; i < 16; i++) ld(1'b0, i, ref_dmem[i]);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) ref_imem[i] = 0;
    endtask

    task automatic sum_prog();
        clear_prog();
        ref_imem[0] = enc_i('h23, 0, 1, 10);
        ref_imem[1] = enc_j('h03, 3);
        ref_imem[3] = enc_i('h09, 0, 3, 0);
        ref_imem[4] = enc_i('h04, 3, 1, 4);
        ref_imem[5] = enc_i('h23, 3, 4, 0);
        ref_imem[6] = enc_r(2, 4, 2, 'h21);
        ref_imem[7] = enc_i('h09, 3, 3, 1);
        ref_imem[8] = enc_j('h02, 4);
        ref_imem[9] = enc_r(31, 0, 0, 'h08);
    endtask

    // Start a run (optionally with a same-cycle imem load), time it and compare to the model.
    task automatic run_prog(input string tag, input int endpc, input bit co_ld,
                            input int co_addr, input int co_data);
        int cyc, last_pc;
        if (co_ld) ref_imem[co_addr] = co_data;
        model_run(endpc);
        end_pc = 8'(endpc);
        @(negedge clk);
        start = 1'b1;
        if (co_ld) begin
            ld_we = 1'b1; ld_imem = 1'b1; ld_addr = 8'(co_addr); ld_data = 32'(co_data);
        end
        @(negedge clk);
        start = 1'b0; ld_we = 1'b0;
        chk({tag, ".busy_rise"}, busy, 1);
        cyc = 0; last_pc = 0;
        trace.delete(); tcyc.delete();
        while (busy && cyc < 400) begin
            cyc++;
            @(negedge clk);
            if (int'(dut.pc_q) != last_pc) begin
                last_pc = int'(dut.pc_q);
                trace.push_back(last_pc);
                tcyc.push_back(cyc);
            end
        end
        if (m_hang) begin
            chk({tag, ".still_busy"}, busy, 1);
        end else begin
            chk({tag, ".done"}, done, !m_err);
            chk({tag, ".err"}, err, m_err);
            chk({tag, ".led"}, led, m_led);
            chk({tag, ".pc"}, dut.pc_q, m_pc);
            chk({tag, ".cycles"}, cyc, m_cyc);
            for (int i = 0; i < 32; i++) chk($sformatf("%s.reg%0d", tag, i), dut.rf_q[i], mreg[i]);
        end
    endtask

    initial begin
        int n, kind, prev_led, pcsnap;
        rst = 1'b1; start = 1'b0; ld_we = 1'b0; ld_imem = 1'b0;
        ld_addr = '0; ld_data = '0; end_pc = '0;
        for (int i = 0; i < 16; i++) begin ref_imem[i] = 0; ref_dmem[i] = 0; end
        m_led = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.err", err, 0);
        chk("reset.led", led, 0);
        chk("reset.pc", dut.pc_q, 0);
        for (int i = 0; i < 32; i++) chk($sformatf("reset.reg%0d", i), dut.rf_q[i], 0);
        load_all();

        // Array sum, then an identical rerun from DONE.
        sum_prog();
        ref_dmem[0] = 1; ref_dmem[1] = 1; ref_dmem[2] = 1; ref_dmem[10] = 3;
        load_all();
        run_prog("sum", 2, 0, 0, 0);
        chk("sum.led_const", led, 3);
        first_cyc = m_cyc;
        run_prog("sum_rerun", 2, 0, 0, 0);
        chk("sum_rerun.led_const", led, 3);
        chk("sum_rerun.same_cycles", m_cyc, first_cyc);

        // Width wrap and signed slt.
        clear_prog();
        ref_imem[0] = enc_i('h09, 0, 1, 'h7F);
        ref_imem[1] = enc_i('h09, 1, 1, 2);
        ref_imem[2] = enc_r(1, 0, 2, 'h21);
        ref_imem[3] = enc_r(1, 0, 2, 'h2A);
        load_all();
        run_prog("wrap", 3, 0, 0, 0);
        chk("wrap.led_const", led, 'h81);
        run_prog("slt", 4, 0, 0, 0);
        chk("slt.led_const", led, 1);
        chk("slt.reg1_const", dut.rf_q[1], 'h81);

        // Branch offsets: golden PC trace, one PC step every 4 cycles.
        clear_prog();
        ref_imem[0] = enc_i('h09, 1, 1, 1);
        ref_imem[1] = enc_i('h09, 0, 2, 1);
        ref_imem[2] = enc_i('h04, 1, 2, -3);
        ref_imem[3] = enc_i('h05, 1, 1, -1);
        load_all();
        run_prog("branch", 4, 0, 0, 0);
        begin
            int golden[7] = '{1, 2, 0, 1, 2, 3, 4};
            chk("branch.trace_len", trace.size(), 7);
            for (int i = 0; i < 7; i++) begin
                if (i < trace.size()) begin
                    chk($sformatf("branch.trace%0d", i), trace[i], golden[i]);
                    chk($sformatf("branch.tcyc%0d", i), tcyc[i], 4 * (i + 1));
                end
            end
        end

        // Fault trapping: bad data address, bad funct, fetch past imem.
        prev_led = int'(led);
        clear_prog();
        ref_imem[0] = enc_i('h09, 0, 2, 7);
        ref_imem[1] = enc_i('h23, 0, 1, 20);
        load_all();
        run_prog("lw_fault", 5, 0, 0, 0);
        chk("lw_fault.err_const", err, 1);
        chk("lw_fault.led_kept", led, prev_led);
        chk("lw_fault.pc_const", dut.pc_q, 1);
        clear_prog();
        ref_imem[0] = enc_r(1, 2, 3, 'h3F);
        load_all();
        run_prog("funct_fault", 5, 0, 0, 0);
        chk("funct_fault.err_const", err, 1);
        clear_prog();
        ref_imem[0] = enc_j('h02, 20);
        load_all();
        run_prog("fetch_fault", 5, 0, 0, 0);
        chk("fetch_fault.pc_const", dut.pc_q, 20);

        // sw round trip.
        clear_prog();
        ref_imem[0] = enc_i('h09, 0, 1, 'h5A);
        ref_imem[1] = enc_i('h2B, 0, 1, 4);
        ref_imem[2] = enc_i('h23, 0, 2, 4);
        ref_dmem[4] = 'h11;
        load_all();
        run_prog("sw", 3, 0, 0, 0);
        if (SW_EN) chk("sw.led_const", led, 'h5A);
        else chk("sw.err_const", err, 1);

        // Load in the same cycle as start: fetch must see the new word.
        run_prog("coload", 1, 1, 0, enc_i('h09, 0, 2, 'h33));
        chk("coload.led_const", led, 'h33);

        // rst beats start and ld_we in the same cycle.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; ld_we = 1'b1; ld_imem = 1'b1; ld_addr = 0; ld_data = 'hDEADBEEF;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; ld_we = 1'b0;
        m_led = 0;
        chk("rstprio.imem0", dut.imem[0], ref_imem[0]);
        chk("rstprio.led", led, 0);
        @(negedge clk);
        chk("rstprio.busy", busy, 0);

        // Self-loop, dropped load while busy, then rst mid-run.
        clear_prog();
        ref_imem[0] = enc_i('h09, 0, 2, 9);
        ref_imem[1] = enc_i('h04, 0, 0, -1);
        load_all();
        run_prog("hang", 'hFF, 0, 0, 0);
        chk("hang.reg2", dut.rf_q[2], mreg[2]);
        ld(1'b1, 0, 'h12345678);
        chk("busyload.imem0", dut.imem[0], ref_imem[0]);
        pcsnap = int'(dut.pc_q);
        chk("hang.pc", pcsnap, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_led = 0;
        chk("midrst.busy", busy, 0);
        chk("midrst.pc", dut.pc_q, 0);
        chk("midrst.led", led, 0);
        for (int i = 0; i < 32; i++) chk($sformatf("midrst.reg%0d", i), dut.rf_q[i], 0);

        // Randomized array-sum data.
        for (int t = 0; t < 4; t++) begin
            sum_prog();
            for (int i = 0; i < 10; i++) ref_dmem[i] = $urandom_range(0, 255);
            ref_dmem[10] = $urandom_range(0, 9);
            load_all();
            run_prog($sformatf("rsum%0d", t), 2, 0, 0, 0);
        end

        // Randomized forward-only programs.
        for (int t = 0; t < 20; t++) begin
            int fns[5] = '{'h21, 'h23, 'h24, 'h25, 'h2A};
            clear_prog();
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                kind = $urandom_range(0, 9);
                if (kind == 9 && k >= n - 1) kind = 5;
                if (kind <= 4)
                    ref_imem[k] = enc_r($urandom_range(0, 7), $urandom_range(0, 7),
                                        $urandom_range(0, 7), fns[$urandom_range(0, 4)]);
                else if (kind <= 6)
                    ref_imem[k] = enc_i('h09, $urandom_range(0, 7), $urandom_range(1, 7),
                                        $urandom_range(0, 65535));
                else if (kind == 7)
                    ref_imem[k] = enc_i('h23, 0, $urandom_range(1, 7), $urandom_range(0, 19));
                else if (kind == 8)
                    ref_imem[k] = enc_i('h2B, 0, $urandom_range(0, 7), $urandom_range(0, 19));
                else
                    ref_imem[k] = enc_i($urandom_range(4, 5), $urandom_range(0, 3),
                                        $urandom_range(0, 3), 1);
            end
            for (int i = 0; i < 16; i++) ref_dmem[i] = $urandom_range(0, 255);
            load_all();
            run_prog($sformatf("rand%0d", t), n, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
